// File: rtl/lce_pkg.sv
// Shared widths and FSM state type for the local-contrast-enhancement result path.
package lce_pkg;

  localparam int PIX_W  = 8;
  localparam int RES_W  = 10;
  localparam int IDX_W  = 15;
  localparam int ADDR_W = 17;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } rw_state_t;

endpackage

// File: rtl/rw_fifo.sv
// Small synchronous FIFO for result words; head is visible combinationally once written,
// but a word written on an edge is never presented before that edge (no fall-through).
module rw_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 25
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      if (push && !pop) begin
        count_reg <= count_reg + (AW+1)'(1);
      end else if (pop && !push) begin
        count_reg <= count_reg - (AW+1)'(1);
      end
    end
  end

  assign dout  = mem[rd_ptr_reg];
  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign empty = (count_reg == '0);

endmodule

// File: rtl/result_writer.sv
// Buffers enhanced result words and writes them as 8-bit pixels to the output memory.
// Optional macro RESULT_WRITER_SATURATE_EN clamps pixels to 0..255 instead of truncating.
module result_writer
  import lce_pkg::*;
#(
  parameter int IMG_W      = 128,
  parameter int IMG_H      = 128,
  parameter int BASE_ADDR  = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IDX_W-1:0]  in_index,
  input  logic [RES_W-1:0]  in_pixel,
  output logic              wen2,
  output logic [ADDR_W-1:0] addr2,
  output logic [PIX_W-1:0]  din2,
  output logic              busy,
  output logic              done,
  output logic              err_range
);

  localparam int          WORD_W = IDX_W + RES_W;
  localparam logic [IDX_W:0] TOTAL = (IDX_W+1)'(IMG_W * IMG_H);

  rw_state_t state_reg, state_next;

  logic [IDX_W:0]    wr_cnt_reg;
  logic              fifo_clr;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic [WORD_W-1:0] fifo_head;
  logic [IDX_W-1:0]  head_index;
  logic [RES_W-1:0]  head_pixel;
  logic              xfer;
  logic              in_range;
  logic              start_pass;
  logic [PIX_W-1:0]  pixel_conv;

  always_comb begin
    state_next = state_reg;
    fifo_clr   = 1'b0;
    start_pass = 1'b0;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_next = ST_RUN;
          fifo_clr   = 1'b1;
          start_pass = 1'b1;
        end
      end
      ST_RUN: begin
        // Pass complete: leftover buffered words are flushed, not written.
        if (wr_cnt_reg == TOTAL) begin
          state_next = ST_DONE;
          fifo_clr   = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_reg == ST_RUN) && !fifo_full;
  assign xfer      = in_valid && in_ready;
  assign in_range  = ({1'b0, in_index} < TOTAL);
  assign fifo_push = xfer && in_range && !fifo_clr;
  assign fifo_pop  = (state_reg == ST_RUN) && !fifo_empty && (wr_cnt_reg != TOTAL);

  rw_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (WORD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (fifo_clr),
    .push  (fifo_push),
    .din   ({in_index, in_pixel}),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_index = fifo_head[WORD_W-1:RES_W];
  assign head_pixel = fifo_head[RES_W-1:0];

`ifdef RESULT_WRITER_SATURATE_EN
  always_comb begin
    if (head_pixel[RES_W-1]) begin
      pixel_conv = '0;
    end else if (|head_pixel[RES_W-2:PIX_W]) begin
      pixel_conv = '1;
    end else begin
      pixel_conv = head_pixel[PIX_W-1:0];
    end
  end
`else
  assign pixel_conv = head_pixel[PIX_W-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      wr_cnt_reg <= '0;
      err_range  <= 1'b0;
      wen2       <= 1'b0;
      addr2      <= '0;
      din2       <= '0;
    end else begin
      state_reg <= state_next;
      wen2      <= fifo_pop;
      if (start_pass) begin
        wr_cnt_reg <= '0;
        err_range  <= 1'b0;
      end else begin
        if (fifo_pop) begin
          wr_cnt_reg <= wr_cnt_reg + (IDX_W+1)'(1);
        end
        if (xfer && !in_range) begin
          err_range <= 1'b1;
        end
      end
      if (fifo_pop) begin
        addr2 <= ADDR_W'(BASE_ADDR) + ADDR_W'(head_index);
        din2  <= pixel_conv;
      end
    end
  end

  assign busy = (state_reg == ST_RUN);
  assign done = (state_reg == ST_DONE);

endmodule

// File: tb/tb_result_writer.sv
// Randomised bench for result_writer against a queue-based model of the write pass.
// Honours RESULT_WRITER_SATURATE_EN when computing expected pixel data.
module tb_result_writer;

  localparam int IMG_W = 4;
  localparam int IMG_H = 2;
  localparam int TOTAL = IMG_W * IMG_H;
  localparam int BASE  = 100;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [14:0] in_index = '0;
  logic [9:0]  in_pixel = '0;
  logic        wen2;
  logic [16:0] addr2;
  logic [7:0]  din2;
  logic        busy;
  logic        done;
  logic        err_range;

  result_writer #(
    .IMG_W      (IMG_W),
    .IMG_H      (IMG_H),
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_index  (in_index),
    .in_pixel  (in_pixel),
    .wen2      (wen2),
    .addr2     (addr2),
    .din2      (din2),
    .busy      (busy),
    .done      (done),
    .err_range (err_range)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int pix;
  } word_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: 0 idle, 1 run, 2 done.
  int    m_state = 0;
  int    m_writes = 0;
  int    m_err = 0;
  int    m_wen = 0;
  int    m_addr = 0;
  int    m_data = 0;
  word_t m_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int conv(input int pix);
`ifdef RESULT_WRITER_SATURATE_EN
    if (pix < 0) return 0;
    if (pix > 255) return 255;
    return pix;
`else
    return pix & 255;
`endif
  endfunction

  // One clock cycle: check what the DUT shows now, drive inputs, advance the model.
  task automatic step(input bit r, input bit s, input bit v, input int idx, input int pix);
    bit    acc;
    word_t w;
    @(negedge clk);
    check("in_ready", in_ready, (m_state == 1 && m_q.size() < DEPTH) ? 1 : 0);
    check("wen2", wen2, m_wen);
    check("addr2", addr2, m_addr);
    check("din2", din2, m_data);
    check("busy", busy, (m_state == 1) ? 1 : 0);
    check("done", done, (m_state == 2) ? 1 : 0);
    check("err_range", err_range, m_err);
    if (m_wen != 0) begin
      $display("write  addr=%0d data=%0d  dut addr=%0d data=%0d", m_addr, m_data, addr2, din2);
    end
    rst      = r;
    start    = s;
    in_valid = v;
    in_index = idx[14:0];
    in_pixel = pix[9:0];
    if (r) begin
      m_state = 0; m_writes = 0; m_err = 0; m_wen = 0; m_addr = 0; m_data = 0;
      m_q.delete();
      return;
    end
    if (m_state != 1) begin
      m_wen = 0;
      if (s) begin
        m_state = 1; m_writes = 0; m_err = 0;
        m_q.delete();
      end
    end else begin
      acc = v && (m_q.size() < DEPTH);
      if (acc && idx >= TOTAL) m_err = 1;
      if (m_writes == TOTAL) begin
        m_state = 2;
        m_wen   = 0;
        m_q.delete();
      end else begin
        if (m_q.size() > 0) begin
          w = m_q.pop_front();
          m_wen  = 1;
          m_addr = BASE + w.idx;
          m_data = conv(w.pix);
          m_writes++;
        end else begin
          m_wen = 0;
        end
        if (acc && idx < TOTAL) begin
          w.idx = idx;
          w.pix = pix;
          m_q.push_back(w);
        end
      end
    end
  endtask

  initial begin
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 10);
    step(0, 0, 1, 1, 20);
    step(0, 0, 1, 2, 30);
    step(0, 0, 1, 3, 40);
    step(0, 0, 1, 4, -5);
    step(0, 0, 1, 5, 300);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 16384, 77);
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 6, 511);
    step(0, 0, 1, 7, -512);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 1);
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 2, 200);
    step(0, 0, 1, 3, 201);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 3, 3);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 150) == 0,
           ($urandom % 20) == 0,
           ($urandom % 4) != 0,
           int'($urandom_range(0, TOTAL + 3)),
           int'($urandom_range(0, 1023)) - 512);
    end
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/result_writer.md
RESULT_WRITER -- requirements
Module: result_writer

Interface
REQ-001 Parameter IMG_W, default 128: output image width in pixels.
REQ-002 Parameter IMG_H, default 128: output image height in pixels.
REQ-003 Parameter BASE_ADDR, default 0: output-memory address of pixel index 0.
REQ-004 Parameter FIFO_DEPTH, default 4: input buffer depth; power of two, at least 2.
REQ-005 clk  in  1  single clock; all state rising-edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 start  in  1  single-cycle pulse; begins one image write pass.
REQ-008 in_valid  in  1  result word present.
REQ-009 in_ready  out  1  block can accept a result word.
REQ-010 in_index  in  15  raster pixel index of the result (row*IMG_W+col).
REQ-011 in_pixel  in  10  signed enhanced pixel value from the window datapath.
REQ-012 wen2  out  1  output-memory write enable.
REQ-013 addr2  out  17  output-memory address.
REQ-014 din2  out  8  output-memory write data.
REQ-015 busy  out  1  high while in RUN.
REQ-016 done  out  1  high in DONE state.
REQ-017 err_range  out  1  sticky flag: an out-of-range index was dropped.

Function
REQ-018 FSM states are IDLE, RUN and DONE; reset enters IDLE.
REQ-019 IDLE->RUN on start; on this transition the write counter, FIFO and err_range clear.
REQ-020 start in RUN is ignored; start in DONE behaves as in IDLE.
REQ-021 in_ready = (state==RUN) && !fifo_full, combinational; a word transfers when in_valid && in_ready.
REQ-022 Transferred words with in_index >= IMG_W*IMG_H are discarded, set err_range, and are not counted.
REQ-023 In-range words enter the FIFO; the FIFO head pops at most once per cycle while in RUN.
REQ-024 A pop drives wen2=1 for exactly one cycle, with addr2=BASE_ADDR+in_index (17-bit, zero-extended) and din2 the converted pixel; all three are registered outputs.
REQ-025 Latency: a word accepted into an empty FIFO at cycle N appears on wen2 at cycle N+1.
REQ-026 Simultaneous push and pop leaves occupancy unchanged; push when full is impossible because in_ready is low.
REQ-027 The write counter increments on each wen2; when it reaches IMG_W*IMG_H, the FSM enters DONE on the next edge and remaining FIFO words are discarded.
REQ-028 Duplicate indices are written again and counted again; the block does not deduplicate.
REQ-029 In IDLE and DONE: wen2=0 and in_ready=0; addr2 and din2 hold their last values.

Reset
REQ-030 Asserting rst at any time, including mid-pass, forces IDLE and empties the FIFO on the same edge.
REQ-031 On rst, outputs are in_ready=0, wen2=0, addr2=0, din2=0, busy=0, done=0 and err_range=0.
REQ-032 No memory write occurs in the cycle following reset release.

Configuration
REQ-033 Macro RESULT_WRITER_SATURATE_EN: when defined, din2 is in_pixel clamped to 0..255 (negative values give 0, values above 255 give 255).
REQ-034 When RESULT_WRITER_SATURATE_EN is undefined, din2 = in_pixel[7:0] (truncation); all other behaviour is identical.

Structure
REQ-035 Shared package lce_pkg holds PIX_W=8, RES_W=10, IDX_W=15, ADDR_W=17 and the FSM state typedef.
REQ-036 One sub-module, rw_fifo: a synchronous FIFO (FIFO_DEPTH, 25-bit word = index+pixel) with full/empty outputs and no fall-through.

Verification
REQ-037 After reset, start, then 4 words (index 0..3, pixel 10,20,30,40), one per cycle -> wen2 pulses at cycles 1..4 after each accept, addr2 0..3, din2 10,20,30,40.
REQ-038 IMG_W=IMG_H=2: after start, 4 in-range words -> done=1 and busy=0 the cycle after the 4th write; in_ready=0 thereafter.
REQ-039 Index 16384 with IMG_W=IMG_H=128 -> no wen2, err_range=1; err_range clears on the next start.
REQ-040 in_pixel=-5 and 300 -> din2=0 and 255 with the macro defined; din2=0xFB and 0x2C without it.
REQ-041 FIFO filled to 4 with in_valid held -> in_ready low only while full, no word lost or reordered; rst mid-burst -> wen2 low next cycle and state IDLE.
